// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Optional perf counters are enabled by PIPE_PERF_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam int MC_MAX_DEF = 64;
  localparam int CNT_W_DEF  = 32;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_valid_chain.sv
// DEC..WRB valid shift register with per-stage load, kill and bubble.
// Kill wins over load; a held stage keeps its current bit.
module pipe_valid_chain (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fch_valid_i,
  input  logic dec_ld_i,
  input  logic dec_kill_i,
  input  logic exe_ld_i,
  input  logic exe_kill_i,
  input  logic mem_bub_i,
  output logic dec_valid_o,
  output logic exe_valid_o,
  output logic mem_valid_o,
  output logic wrb_valid_o
);

  logic dec_q, exe_q, mem_q, wrb_q;
  logic dec_d, exe_d, mem_d, wrb_d;

  // Next valid bit per stage from the controller's per-stage actions.
  always_comb begin
    dec_d = dec_q;
    exe_d = exe_q;
    if (dec_ld_i) dec_d = fch_valid_i;
    if (dec_kill_i) dec_d = 1'b0;
    if (exe_ld_i) exe_d = dec_q;
    if (exe_kill_i) exe_d = 1'b0;
    mem_d = mem_bub_i ? 1'b0 : exe_q;
    wrb_d = mem_q;
  end

  // Valid registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_q <= 1'b0;
      exe_q <= 1'b0;
      mem_q <= 1'b0;
      wrb_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
      exe_q <= exe_d;
      mem_q <= mem_d;
      wrb_q <= wrb_d;
    end
  end

  assign dec_valid_o = dec_q;
  assign exe_valid_o = exe_q;
  assign mem_valid_o = mem_q;
  assign wrb_valid_o = wrb_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline freeze/flush controller for the 5-stage core.
// Define PIPE_PERF_CNT_EN to build the stall performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_MAX = MC_MAX_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fch_valid,
  input  logic             dec_stall,
  input  logic             dec_load_use,
  input  logic             dec_csr_use,
  input  logic             exe_mc_start,
  input  logic             exe_mc_done,
  input  logic             exe_redirect,
  output logic             fch_enb,
  output logic             dec_enb,
  output logic             exe_enb,
  output logic             mem_enb,
  output logic             dec_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wrb_valid,
  output logic             pc_redirect,
  output logic             mc_busy,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] perf_load_stalls,
  output logic [CNT_W-1:0] perf_csr_stalls,
  output logic [CNT_W-1:0] perf_mc_stalls
);

  localparam int WC_W = cnt_bits(MC_MAX);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MC_MAX);

  state_e state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic tmo_q, tmo_d;

  logic stall_ok, redir_ok, mc_ok, hold;
  logic dec_ld, dec_kill, exe_ld, exe_kill, mem_bub;

  assign stall_ok = dec_stall & dec_valid;
  assign redir_ok = exe_redirect & exe_valid
                  & (state_q == RUN);
  assign mc_ok    = exe_mc_start & exe_valid
                  & ~exe_mc_done & (state_q == RUN);
  assign hold     = ((state_q == MC_WAIT) & ~exe_mc_done)
                  | mc_ok;

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state; the wait counter only runs while parked in MC_WAIT.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    tmo_d   = tmo_q;
    unique case (state_q)
      RUN: begin
        if (mc_ok) state_d = MC_WAIT;
      end
      MC_WAIT: begin
        if (exe_mc_done) state_d = RUN;
        wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q
               : wcnt_q + WC_W'(1);
        if (wcnt_d == WC_MAX) tmo_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Enables and valid-chain actions by priority: hold, redirect, stall.
  always_comb begin
    fch_enb     = 1'b1;
    dec_enb     = 1'b1;
    exe_enb     = 1'b1;
    mem_enb     = 1'b1;
    pc_redirect = 1'b0;
    dec_ld      = 1'b1;
    exe_ld      = 1'b1;
    dec_kill    = 1'b0;
    exe_kill    = 1'b0;
    mem_bub     = 1'b0;
    priority case (1'b1)
      hold: begin
        fch_enb = 1'b0;
        dec_enb = 1'b0;
        exe_enb = 1'b0;
        dec_ld  = 1'b0;
        exe_ld  = 1'b0;
        mem_bub = 1'b1;
      end
      redir_ok: begin
        pc_redirect = 1'b1;
        dec_kill    = 1'b1;
        exe_kill    = 1'b1;
      end
      stall_ok: begin
        fch_enb  = 1'b0;
        dec_enb  = 1'b0;
        dec_ld   = 1'b0;
        exe_kill = 1'b1;
      end
      default: ;
    endcase
  end

  pipe_valid_chain u_chain (
    .clk_i       (clk),
    .rst_i       (rst),
    .fch_valid_i (fch_valid),
    .dec_ld_i    (dec_ld),
    .dec_kill_i  (dec_kill),
    .exe_ld_i    (exe_ld),
    .exe_kill_i  (exe_kill),
    .mem_bub_i   (mem_bub),
    .dec_valid_o (dec_valid),
    .exe_valid_o (exe_valid),
    .mem_valid_o (mem_valid),
    .wrb_valid_o (wrb_valid)
  );

  assign mc_busy    = (state_q == MC_WAIT);
  assign mc_timeout = tmo_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] pl_q, pc_q, pm_q;

  // Free-running wrap-around stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pl_q <= '0;
      pc_q <= '0;
      pm_q <= '0;
    end else begin
      pl_q <= pl_q + CNT_W'(stall_ok & dec_load_use);
      pc_q <= pc_q + CNT_W'(stall_ok & dec_csr_use);
      pm_q <= pm_q + CNT_W'(state_q == MC_WAIT);
    end
  end

  assign perf_load_stalls = pl_q;
  assign perf_csr_stalls  = pc_q;
  assign perf_mc_stalls   = pm_q;
`else
  logic unused_perf;
  assign unused_perf      = dec_load_use ^ dec_csr_use;
  assign perf_load_stalls = '0;
  assign perf_csr_stalls  = '0;
  assign perf_mc_stalls   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level model.
// Expects perf counters only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_ctrl;

  localparam int MC_MAX = 4;
  localparam int CNT_W  = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, fch_valid, dec_stall, dec_load_use, dec_csr_use;
  logic exe_mc_start, exe_mc_done, exe_redirect;
  logic fch_enb, dec_enb, exe_enb, mem_enb;
  logic dec_valid, exe_valid, mem_valid, wrb_valid;
  logic pc_redirect, mc_busy, mc_timeout;
  logic [CNT_W-1:0] perf_load_stalls, perf_csr_stalls, perf_mc_stalls;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .fch_valid        (fch_valid),
    .dec_stall        (dec_stall),
    .dec_load_use     (dec_load_use),
    .dec_csr_use      (dec_csr_use),
    .exe_mc_start     (exe_mc_start),
    .exe_mc_done      (exe_mc_done),
    .exe_redirect     (exe_redirect),
    .fch_enb          (fch_enb),
    .dec_enb          (dec_enb),
    .exe_enb          (exe_enb),
    .mem_enb          (mem_enb),
    .dec_valid        (dec_valid),
    .exe_valid        (exe_valid),
    .mem_valid        (mem_valid),
    .wrb_valid        (wrb_valid),
    .pc_redirect      (pc_redirect),
    .mc_busy          (mc_busy),
    .mc_timeout       (mc_timeout),
    .perf_load_stalls (perf_load_stalls),
    .perf_csr_stalls  (perf_csr_stalls),
    .perf_mc_stalls   (perf_mc_stalls)
  );

  wire [4:0] obs_c = {fch_enb, dec_enb, exe_enb,
                      mem_enb, pc_redirect};
  wire [17:0] obs_r = {dec_valid, exe_valid, mem_valid,
                       wrb_valid, mc_busy, mc_timeout,
                       perf_load_stalls, perf_csr_stalls,
                       perf_mc_stalls};

  // Model: which stages hold live instructions, whether the pipe is
  // parked on a multi-cycle op, and plain integer event tallies.
  bit mv [4];
  bit m_wait, m_to;
  int m_wc, m_pl, m_pc, m_pm;

  function automatic logic [4:0] exp_comb();
    bit sq, rd, mc;
    sq = dec_stall & mv[0];
    rd = exe_redirect & mv[1] & !m_wait;
    mc = exe_mc_start & mv[1] & !exe_mc_done & !m_wait;
    if ((m_wait && !exe_mc_done) || mc) return 5'b00010;
    if (rd) return 5'b11111;
    if (sq) return 5'b00110;
    return 5'b11110;
  endfunction

  function automatic logic [17:0] exp_reg();
    logic [11:0] p;
    p = PERF ? {4'(m_pl), 4'(m_pc), 4'(m_pm)} : 12'd0;
    return {mv[0], mv[1], mv[2], mv[3], m_wait, m_to, p};
  endfunction

  task automatic model_adv();
    bit sq, rd, mc, hold;
    bit nv [4];
    if (rst) begin
      foreach (mv[k]) mv[k] = 1'b0;
      m_wait = 0; m_to = 0; m_wc = 0;
      m_pl = 0; m_pc = 0; m_pm = 0;
      return;
    end
    sq = dec_stall & mv[0];
    rd = exe_redirect & mv[1] & !m_wait;
    mc = exe_mc_start & mv[1] & !exe_mc_done & !m_wait;
    hold = (m_wait && !exe_mc_done) || mc;
    m_pl += int'(sq & dec_load_use);
    m_pc += int'(sq & dec_csr_use);
    m_pm += int'(m_wait);
    if (hold) nv = '{mv[0], mv[1], 1'b0, mv[2]};
    else if (rd) nv = '{1'b0, 1'b0, 1'b1, mv[2]};
    else if (sq) nv = '{mv[0], 1'b0, mv[1], mv[2]};
    else nv = '{fch_valid, mv[0], mv[1], mv[2]};
    mv = nv;
    if (m_wait) begin
      m_wc++;
      if (m_wc >= MC_MAX) m_to = 1;
      m_wait = !exe_mc_done;
    end else begin
      m_wc = 0;
      m_wait = mc;
    end
  endtask

  task automatic drive(input bit r, fv, st, lu, cu,
                       ms, md, rd);
    rst = r; fch_valid = fv; dec_stall = st;
    dec_load_use = lu; dec_csr_use = cu;
    exe_mc_start = ms; exe_mc_done = md;
    exe_redirect = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_adv();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i == 5, 1, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL rst_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      if (i == 4) begin
        total++;
        if ({dec_valid, exe_valid, mem_valid, wrb_valid}
            !== 4'b1111) begin
          bad++;
          $display("FAIL rst_fill got=%b exp=1111",
                   {dec_valid, exe_valid, mem_valid, wrb_valid});
        end
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL rst_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
    end
    total++;
    if (obs_r !== 18'd0) begin
      bad++;
      $display("FAIL rst_clear got=%h exp=0", obs_r);
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(0, 1, 0, 0, 0, 0, 0, 0);
      else if (i == 2) drive(0, 1, 1, 1, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL lu_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      if (i == 2) begin
        total++;
        if ({fch_enb, dec_enb} !== 2'b00) begin
          bad++;
          $display("FAIL lu_freeze got=%b exp=00",
                   {fch_enb, dec_enb});
        end
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL lu_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
      if (i == 2) begin
        total++;
        if ({dec_valid, exe_valid, perf_load_stalls}
            !== {2'b10, (PERF ? 4'd1 : 4'd0)}) begin
          bad++;
          $display("FAIL lu_after got=%b%b cnt=%0d exp=10 cnt=%0d",
                   dec_valid, exe_valid, perf_load_stalls,
                   PERF ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(0, 1, 0, 0, 0, 0, 0, 0);
      else if (i == 3) drive(0, 1, 1, 0, 1, 0, 0, 1);
      else drive(0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL rd_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      if (i == 3) begin
        total++;
        if (obs_c !== 5'b11111) begin
          bad++;
          $display("FAIL rd_redirect got=%b exp=11111", obs_c);
        end
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL rd_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
      if (i == 3) begin
        total++;
        if ({dec_valid, exe_valid, mem_valid} !== 3'b001) begin
          bad++;
          $display("FAIL rd_kill got=%b exp=001",
                   {dec_valid, exe_valid, mem_valid});
        end
      end
    end
  endtask

  task automatic test_mc_op();
    int busy = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) drive(1, 0, 0, 0, 0, 0, 0, 0);
      else if (i < 3) drive(0, 1, 0, 0, 0, 0, 0, 0);
      else if (i < 8) drive(0, 1, 0, 0, 0, 1, 0, 0);
      else if (i == 8) drive(0, 1, 0, 0, 0, 1, 1, 0);
      else drive(0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL mc_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      if (i >= 3 && i < 8) begin
        total++;
        if ({fch_enb, dec_enb, exe_enb, mem_enb} !== 4'b0001)
        begin
          bad++;
          $display("FAIL mc_freeze cyc=%0d got=%b exp=0001",
                   i, {fch_enb, dec_enb, exe_enb, mem_enb});
        end
      end
      busy += int'(mc_busy);
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL mc_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
    end
    total++;
    if (busy !== 5) begin
      bad++;
      $display("FAIL mc_busy_cycles got=%0d exp=5", busy);
    end
    total++;
    if (perf_mc_stalls !== (PERF ? 4'd5 : 4'd0)) begin
      bad++;
      $display("FAIL mc_perf got=%0d exp=%0d",
               perf_mc_stalls, PERF ? 5 : 0);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 18; i++) begin
      if (i == 0 || i == 17) drive(1, 0, 0, 0, 0, 0, 0, 0);
      else if (i < 3) drive(0, 1, 0, 0, 0, 0, 0, 0);
      else if (i < 13) drive(0, 1, 0, 0, 0, 1, 0, 0);
      else if (i == 13) drive(0, 0, 0, 0, 0, 1, 1, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL to_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL to_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
      if (i >= 3) begin
        total++;
        if (mc_timeout !== (i >= 7 && i < 17)) begin
          bad++;
          $display("FAIL to_flag cyc=%0d got=%b exp=%b",
                   i, mc_timeout, (i >= 7 && i < 17));
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) drive(1, 0, 0, 0, 0, 0, 0, 0);
      else if (i == 1) drive(0, 1, 0, 0, 0, 0, 0, 0);
      else if (i < 19) drive(0, 0, 1, 1, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL wr_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL wr_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
    end
    total++;
    if (perf_load_stalls !== (PERF ? 4'd1 : 4'd0)) begin
      bad++;
      $display("FAIL wr_count got=%0d exp=%0d",
               perf_load_stalls, PERF ? 1 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(49) == 0,
            $urandom_range(3) != 0,
            $urandom_range(2) == 0,
            $urandom_range(1) == 0,
            $urandom_range(1) == 0,
            $urandom_range(5) == 0,
            $urandom_range(3) == 0,
            $urandom_range(4) == 0);
      #1;
      total++;
      if (obs_c !== exp_comb()) begin
        bad++;
        $display("FAIL rnd_enb cyc=%0d got=%b exp=%b",
                 i, obs_c, exp_comb());
      end
      tick();
      total++;
      if (obs_r !== exp_reg()) begin
        bad++;
        $display("FAIL rnd_reg cyc=%0d got=%h exp=%h",
                 i, obs_r, exp_reg());
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    test_reset();
    test_load_use();
    test_redirect();
    test_mc_op();
    test_timeout();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

endmodule
